led_frame_buffer: RTL and testbench
===================================

Name: led_frame_buffer

Overview:
- Upstream feeder for the WS2812 chain driver.
- Accepts a byte stream of pixel colours (R,G,B order per pixel, e.g. from the UART receiver) into a back bank of a double-buffered LEDNUM-entry GRB store.
- Swaps banks at frame boundaries and issues a periodic one-cycle ready strobe that starts a chain refresh.
- Serves the driver's pixel read address combinationally from the front bank.

Parameters:
- LEDNUM, 25, pixels per frame (1..63).
- REFRESH_CYCLES, 500000, clk cycles between ready strobes; must exceed the driver's full-frame time plus the latch time (>= 2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sof  in  1  start-of-frame strobe; resynchronises byte/pixel counters
- byte_valid  in  1  byte_data qualifier, one byte per cycle
- byte_data  in  8  colour byte
- addr_counter  in  6  pixel index from driver
- GRB  out  24  {G,R,B} of front[addr_counter]
- ready  out  1  one-cycle refresh-start strobe to driver
- frame_valid  out  1  high once any complete frame has been displayed-swapped
- overrun  out  1  sticky: bytes dropped since last sof

Behaviour:
- Reset (async, rst_n=0): ready=0, frame_valid=0, overrun=0; byte_cnt=0, pix_cnt=0, refresh counter=0, swap_pending=0, front_sel=0. Bank contents are not reset.
- GRB output:
  - GRB = front bank entry at addr_counter, purely combinational (driver samples it in the cycle after updating addr).
  - addr_counter >= LEDNUM -> GRB=24'h0.
  - frame_valid=0 -> GRB=24'h0.
- Write path (states IDLE, FILL, FULL):
  - IDLE: wait for sof; on sof -> FILL, byte_cnt=0, pix_cnt=0, overrun cleared.
  - FILL: on byte_valid, byte_cnt cycles 0->1->2->0.
    - Byte 0 latched as R, byte 1 as G.
    - Byte 2 (B) commits {G,R,B} to back[pix_cnt] on that edge and increments pix_cnt.
    - When pix_cnt reaches LEDNUM after a commit -> FULL, swap_pending=1.
  - FULL: byte_valid without sof is ignored and sets overrun. sof while swap_pending=1 is ignored and sets overrun. sof with swap_pending=0 -> FILL.
  - sof in FILL: partial frame discarded (back bank partially overwritten, never swapped), counters cleared, stay in FILL.
  - sof and byte_valid in the same cycle: sof wins, byte discarded.
- Refresh timer: free-running 0..REFRESH_CYCLES-1, wraps to 0.
  - At terminal count, on the same edge: if swap_pending, then front_sel toggles, swap_pending=0, frame_valid=1.
  - On the next cycle ready=1 for exactly one cycle, provided frame_valid=1 (including a swap just made).
  - frame_valid=0 -> no ready strobes.
  - With no new frame, ready keeps strobing each period and the same frame is re-sent.
- Swap coincident with a sof in FULL: swap processed first; that sof is accepted (goes to FILL) because swap_pending clears on that edge.
- Swap timing: a swap never happens between ready strobes, so the front bank is stable for a whole driver frame as long as REFRESH_CYCLES satisfies its constraint.
- Mid-operation reset: all control state clears immediately; ready deasserts asynchronously. After release, no ready until a new full frame completes.
- Widths:
  - Refresh counter: clog2(REFRESH_CYCLES) bits.
  - pix_cnt: 6 bits.
  - Storage: 2 x LEDNUM x 24 bits. Distributed/register array, single write port, one async read port.

Test Plan:
- Reset, then sof + 9 bytes (LEDNUM=3, REFRESH_CYCLES=20): 11,22,33,44,55,66,77,88,99 -> after next terminal count, frame_valid=1, ready one-cycle pulse; addr 0/1/2 read 22_11_33, 55_44_66, 88_77_99; addr 3 reads 000000.
- No further input for 3 periods -> ready pulses exactly every 20 cycles, GRB contents unchanged.
- Second frame completes mid-period -> GRB still shows old frame until the terminal-count edge, new frame visible at the following ready pulse; no swap mid-period.
- Complete a frame, then sof + bytes before the swap -> overrun=1, bytes dropped, pending frame intact; next sof after the swap clears overrun and fills normally.
- sof after 4 bytes of a frame, then 9 fresh bytes -> only the fresh frame is displayed; sof+byte_valid in the same cycle drops that byte.
- rst_n low for 1 cycle mid-FILL and just after a swap -> ready never pulses; frame_valid=0 and GRB=0 until a full new frame completes.

Source files
------------

// File: rtl/led_frame_buffer.sv
// Double-buffered GRB pixel store feeding the WS2812 chain driver.
// Bytes fill the back bank; banks swap only at refresh terminal count.
module led_frame_buffer #(
  parameter int unsigned LEDNUM         = 25,
  parameter int unsigned REFRESH_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sof,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic [5:0]  addr_counter,
  output logic [23:0] GRB,
  output logic        ready,
  output logic        frame_valid,
  output logic        overrun
);

  localparam int unsigned CntW = $clog2(REFRESH_CYCLES);
  localparam int unsigned IdxW = (LEDNUM > 1) ? $clog2(LEDNUM) : 1;
  localparam logic [CntW-1:0] TermCnt = CntW'(REFRESH_CYCLES - 1);
  localparam logic [5:0]      LastPix = 6'(LEDNUM - 1);
  localparam logic [5:0]      NumPix  = 6'(LEDNUM);

  typedef enum logic [1:0] {StIdle, StFill, StFull} state_e;

  state_e          state_q;
  logic [1:0]      byte_cnt_q;
  logic [5:0]      pix_cnt_q;
  logic [7:0]      r_q, g_q;
  logic [CntW-1:0] refresh_cnt_q;
  logic            swap_pending_q, front_sel_q, frame_valid_q, overrun_q, ready_q;
  logic [23:0]     bank_q [2][LEDNUM];

  logic tc, swap, sof_ok, byte_in, commit;

  assign tc      = (refresh_cnt_q == TermCnt);
  assign swap    = tc & swap_pending_q;
  // A pending frame blocks a new sof unless it is swapped out on this very edge.
  assign sof_ok  = sof & ((state_q != StFull) | ~swap_pending_q | tc);
  assign byte_in = (state_q == StFill) & byte_valid & ~sof;
  assign commit  = byte_in & (byte_cnt_q == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      byte_cnt_q     <= '0;
      pix_cnt_q      <= '0;
      r_q            <= '0;
      g_q            <= '0;
      refresh_cnt_q  <= '0;
      swap_pending_q <= 1'b0;
      front_sel_q    <= 1'b0;
      frame_valid_q  <= 1'b0;
      overrun_q      <= 1'b0;
      ready_q        <= 1'b0;
    end else begin
      refresh_cnt_q <= tc ? '0 : refresh_cnt_q + 1'b1;
      ready_q       <= tc & (frame_valid_q | swap_pending_q);

      if (swap) begin
        front_sel_q    <= ~front_sel_q;
        swap_pending_q <= 1'b0;
        frame_valid_q  <= 1'b1;
      end

      if (sof_ok) begin
        state_q    <= StFill;
        byte_cnt_q <= '0;
        pix_cnt_q  <= '0;
        overrun_q  <= 1'b0;
      end else if ((state_q == StFull) && (sof || byte_valid)) begin
        overrun_q <= 1'b1;
      end else if (byte_in) begin
        unique case (byte_cnt_q)
          2'd0: begin
            r_q        <= byte_data;
            byte_cnt_q <= 2'd1;
          end
          2'd1: begin
            g_q        <= byte_data;
            byte_cnt_q <= 2'd2;
          end
          default: begin
            byte_cnt_q <= 2'd0;
            pix_cnt_q  <= pix_cnt_q + 1'b1;
            if (pix_cnt_q == LastPix) begin
              state_q        <= StFull;
              swap_pending_q <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      bank_q[~front_sel_q][pix_cnt_q[IdxW-1:0]] <= {g_q, r_q, byte_data};
    end
  end

  always_comb begin
    GRB = '0;
    if (frame_valid_q && (addr_counter < NumPix)) begin
      GRB = bank_q[front_sel_q][addr_counter[IdxW-1:0]];
    end
  end

  assign ready       = ready_q;
  assign frame_valid = frame_valid_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Bench for led_frame_buffer: frame-level reference model (byte queue, pending and
// displayed pixel arrays) driven by directed scenarios and random traffic.
module tb_led_frame_buffer;
  localparam int L = 3;
  localparam int R = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sof = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic [5:0]  addr_counter = '0;
  logic [23:0] GRB;
  logic        ready, frame_valid, overrun;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  led_frame_buffer #(.LEDNUM(L), .REFRESH_CYCLES(R)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sof         (sof),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .addr_counter(addr_counter),
    .GRB         (GRB),
    .ready       (ready),
    .frame_valid (frame_valid),
    .overrun     (overrun)
  );

  // Reference model: k counts clock edges since reset release.
  int          k;
  int          mst;  // 0 idle, 1 filling, 2 full
  logic [7:0]  q[$];
  logic [23:0] pend[L];
  logic [23:0] disp[L];
  bit          pending, fv, ovr, rdy;
  logic [7:0]  fb[3*L];
  logic [23:0] pix_a[L];

  task automatic model_reset();
    k = 0; mst = 0; q.delete(); pending = 0; fv = 0; ovr = 0; rdy = 0;
  endtask

  task automatic model_edge(input bit s, input bit bv, input logic [7:0] d);
    bit tc, pend_old, fv_old;
    tc = ((k % R) == R - 1);
    pend_old = pending;
    fv_old = fv;
    if (s && (mst != 2 || !pend_old || tc)) begin
      mst = 1; q.delete(); ovr = 0;
    end else if (mst == 2 && (s || bv)) begin
      ovr = 1;
    end else if (mst == 1 && bv) begin
      q.push_back(d);
      if (q.size() == 3 * L) begin
        for (int i = 0; i < L; i++) pend[i] = {q[3*i+1], q[3*i], q[3*i+2]};
        pending = 1;
        mst = 2;
      end
    end
    if (tc && pend_old) begin
      pending = 0;
      disp = pend;
      fv = 1;
    end
    rdy = tc && (fv_old || pend_old);
    k++;
  endtask

  function automatic logic [23:0] exp_grb(input int a);
    return (fv && a < L) ? disp[a] : 24'h0;
  endfunction

  task automatic step(input bit s, input bit bv, input logic [7:0] d);
    sof = s; byte_valid = bv; byte_data = d;
    @(posedge clk);
    if (rst_n) model_edge(s, bv, d);
    #1;
    sof = 1'b0; byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00);
  endtask

  task automatic align();
    while ((k % R) != 0) step(0, 0, 8'h00);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 3 * L; i++) fb[i] = 8'($urandom);
    for (int i = 0; i < L; i++) pix_a[i] = {fb[3*i+1], fb[3*i], fb[3*i+2]};
  endtask

  task automatic send_bytes();
    for (int i = 0; i < 3 * L; i++) step(0, 1, fb[i]);
  endtask

  task automatic send_frame();
    step(1, 0, 8'h00);
    send_bytes();
  endtask

  // Runs idle cycles until the model expects a ready strobe; returns the DUT's ready then.
  task automatic wait_swap(output logic r);
    r = 1'b0;
    for (int i = 0; i < 2 * R; i++) begin
      step(0, 0, 8'h00);
      if (rdy) begin
        r = ready;
        break;
      end
    end
  endtask

  task automatic hit_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #4 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    #12;
    n_chk++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready); else n_pass++;
    n_chk++; if (frame_valid !== 1'b0) $display("FAIL reset_fv: got %b want 0", frame_valid);
    else n_pass++;
    n_chk++; if (overrun !== 1'b0) $display("FAIL reset_ovr: got %b want 0", overrun); else n_pass++;
    n_chk++; if (GRB !== 24'h0) $display("FAIL reset_grb: got %h want 0", GRB); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_frame();
    logic [23:0] want[4];
    logic r;
    want[0] = 24'h221133; want[1] = 24'h554466; want[2] = 24'h887799; want[3] = 24'h0;
    for (int i = 0; i < 9; i++) fb[i] = 8'(8'h11 * (i + 1));
    send_frame();
    n_chk++; if (frame_valid !== 1'b0) $display("FAIL first_fv_early: got %b want 0", frame_valid);
    else n_pass++;
    wait_swap(r);
    n_chk++; if (r !== 1'b1) $display("FAIL first_ready: got %b want 1", r); else n_pass++;
    n_chk++; if (frame_valid !== 1'b1) $display("FAIL first_fv: got %b want 1", frame_valid);
    else n_pass++;
    for (int a = 0; a < 4; a++) begin
      addr_counter = 6'(a);
      #1;
      n_chk++;
      if (GRB !== want[a]) $display("FAIL first_grb[%0d]: got %h want %h", a, GRB, want[a]);
      else n_pass++;
    end
  endtask

  task automatic test_repeat();
    int pulses = 0;
    for (int i = 0; i < 3 * R; i++) begin
      step(0, 0, 8'h00);
      n_chk++; if (ready !== rdy) $display("FAIL repeat_ready@%0d: got %b want %b", k, ready, rdy);
      else n_pass++;
      if (ready === 1'b1) begin
        pulses++;
        addr_counter = 6'd1;
        #1;
        n_chk++; if (GRB !== 24'h554466) $display("FAIL repeat_grb: got %h want 554466", GRB);
        else n_pass++;
      end
    end
    n_chk++; if (pulses != 3) $display("FAIL repeat_pulses: got %0d want 3", pulses); else n_pass++;
  endtask

  task automatic test_mid_period();
    align();
    fill_random();
    send_frame();
    addr_counter = 6'd0;
    #1;
    n_chk++; if (GRB !== 24'h221133) $display("FAIL mid_old0: got %h want 221133", GRB);
    else n_pass++;
    while ((k % R) != R - 1) step(0, 0, 8'h00);
    addr_counter = 6'd2;
    #1;
    n_chk++; if (GRB !== 24'h887799) $display("FAIL mid_old2: got %h want 887799", GRB);
    else n_pass++;
    step(0, 0, 8'h00);
    n_chk++; if (ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", ready); else n_pass++;
    for (int a = 0; a < L; a++) begin
      addr_counter = 6'(a);
      #1;
      n_chk++; if (GRB !== pix_a[a]) $display("FAIL mid_new[%0d]: got %h want %h", a, GRB, pix_a[a]);
      else n_pass++;
    end
  endtask

  task automatic test_overrun();
    logic [23:0] old0, fr_b[L];
    logic r;
    old0 = pix_a[0];
    align();
    fill_random();
    fr_b = pix_a;
    send_frame();
    step(1, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 1, 8'($urandom));
    n_chk++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %b want 1", overrun); else n_pass++;
    addr_counter = 6'd0;
    #1;
    n_chk++; if (GRB !== old0) $display("FAIL ovr_old: got %h want %h", GRB, old0); else n_pass++;
    wait_swap(r);
    n_chk++; if (r !== 1'b1) $display("FAIL ovr_ready: got %b want 1", r); else n_pass++;
    for (int a = 0; a < L; a++) begin
      addr_counter = 6'(a);
      #1;
      n_chk++; if (GRB !== fr_b[a]) $display("FAIL ovr_pend[%0d]: got %h want %h", a, GRB, fr_b[a]);
      else n_pass++;
    end
    n_chk++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun); else n_pass++;
    step(1, 0, 8'h00);
    n_chk++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b want 0", overrun); else n_pass++;
    fill_random();
    send_bytes();
    wait_swap(r);
    for (int a = 0; a < L; a++) begin
      addr_counter = 6'(a);
      #1;
      n_chk++; if (GRB !== pix_a[a]) $display("FAIL ovr_next[%0d]: got %h want %h", a, GRB, pix_a[a]);
      else n_pass++;
    end
  endtask

  task automatic test_sof_restart();
    logic r;
    fill_random();
    step(1, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 1, fb[i]);
    fill_random();
    send_frame();
    wait_swap(r);
    for (int a = 0; a < L; a++) begin
      addr_counter = 6'(a);
      #1;
      n_chk++; if (GRB !== pix_a[a]) $display("FAIL restart[%0d]: got %h want %h", a, GRB, pix_a[a]);
      else n_pass++;
    end
    step(1, 1, 8'hA5);
    fill_random();
    send_bytes();
    wait_swap(r);
    for (int a = 0; a < L; a++) begin
      addr_counter = 6'(a);
      #1;
      n_chk++; if (GRB !== pix_a[a]) $display("FAIL sof_byte[%0d]: got %h want %h", a, GRB, pix_a[a]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic r;
    int bad;
    fill_random();
    step(1, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 1, fb[i]);
    hit_reset();
    release_reset();
    bad = 0;
    for (int i = 0; i < 2 * R; i++) begin
      step(0, 0, 8'h00);
      if (ready !== 1'b0 || frame_valid !== 1'b0 || GRB !== 24'h0) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL rst_fill_quiet: got %0d bad cycles want 0", bad);
    else n_pass++;
    fill_random();
    send_frame();
    wait_swap(r);
    n_chk++; if (r !== 1'b1) $display("FAIL rst_new_ready: got %b want 1", r); else n_pass++;
    hit_reset();
    n_chk++; if (ready !== 1'b0) $display("FAIL rst_async_ready: got %b want 0", ready); else n_pass++;
    addr_counter = 6'd0;
    #1;
    n_chk++; if (GRB !== 24'h0) $display("FAIL rst_async_grb: got %h want 0", GRB); else n_pass++;
    release_reset();
    bad = 0;
    for (int i = 0; i < 2 * R; i++) begin
      step(0, 0, 8'h00);
      if (ready !== 1'b0 || frame_valid !== 1'b0) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL rst_swap_quiet: got %0d bad cycles want 0", bad);
    else n_pass++;
  endtask

  task automatic test_random();
    int a;
    logic [23:0] eg;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, 8'($urandom));
      a = $urandom_range(0, 4);
      addr_counter = 6'(a);
      #1;
      eg = exp_grb(a);
      n_chk++; if (ready !== rdy) $display("FAIL rnd_ready@%0d: got %b want %b", i, ready, rdy);
      else n_pass++;
      n_chk++; if (frame_valid !== fv) $display("FAIL rnd_fv@%0d: got %b want %b", i, frame_valid, fv);
      else n_pass++;
      n_chk++; if (overrun !== ovr) $display("FAIL rnd_ovr@%0d: got %b want %b", i, overrun, ovr);
      else n_pass++;
      n_chk++; if (GRB !== eg) $display("FAIL rnd_grb@%0d: got %h want %h", i, GRB, eg);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_repeat();
    test_mid_period();
    test_overrun();
    test_sof_restart();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
